uart_cmd_parser: RTL

- Consumes the byte stream from the UART receiver (data_out/data_valid, 27 MHz, 115200 baud) and decodes fixed 5-byte command frames from the PC.
- Drives the logic analyzer's control registers (sample divider, trigger mask/value/mode) and one-cycle arm/abort strobes to the capture engine.
- Reports per-frame success or error to the status/TX path.

---
 rtl/la_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_parser.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/la_cmd_pkg.sv
// Shared constants for the logic-analyzer command parser: framing byte,
// opcodes, error codes and the parser state encoding.
package la_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  localparam logic [7:0] OP_SET_DIV   = 8'h01;
  localparam logic [7:0] OP_SET_MASK  = 8'h02;
  localparam logic [7:0] OP_SET_VAL   = 8'h03;
  localparam logic [7:0] OP_SET_MODE  = 8'h04;
  localparam logic [7:0] OP_ARM       = 8'h05;
  localparam logic [7:0] OP_ABORT     = 8'h06;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ARGH = 3'd2,
    S_ARGL = 3'd3,
    S_CHK  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte command frames (SYNC, OP, ARG_H, ARG_L, CHK) from the UART
// receiver into logic-analyzer control registers and capture strobes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | hunting for SYNC; any other byte is dropped silently
// S_OP   | next byte is the opcode
// S_ARGH | next byte is the high argument byte
// S_ARGL | next byte is the low argument byte
// S_CHK  | next byte is the checksum; frame executes or is rejected
module uart_cmd_parser
  import la_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 27000,
  parameter logic [15:0] DIV_RST     = 16'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] sample_div,
  output logic [7:0]  trig_mask,
  output logic [7:0]  trig_val,
  output logic [1:0]  trig_mode,
  output logic        arm,
  output logic        abort,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [1:0]  err_code
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic [7:0]    op_q, op_nxt;
  logic [7:0]    argh_q, argh_nxt;
  logic [7:0]    argl_q, argl_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [15:0]   sample_div_nxt;
  logic [7:0]    trig_mask_nxt, trig_val_nxt;
  logic [1:0]    trig_mode_nxt, err_code_nxt;
  logic          arm_nxt, abort_nxt, cmd_ok_nxt, cmd_err_nxt;

  // State, latched frame bytes, timeout counter and all outputs are registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      op_q       <= '0;
      argh_q     <= '0;
      argl_q     <= '0;
      cnt        <= '0;
      sample_div <= DIV_RST;
      trig_mask  <= '0;
      trig_val   <= '0;
      trig_mode  <= '0;
      arm        <= 1'b0;
      abort      <= 1'b0;
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      argh_q     <= argh_nxt;
      argl_q     <= argl_nxt;
      cnt        <= cnt_nxt;
      sample_div <= sample_div_nxt;
      trig_mask  <= trig_mask_nxt;
      trig_val   <= trig_val_nxt;
      trig_mode  <= trig_mode_nxt;
      arm        <= arm_nxt;
      abort      <= abort_nxt;
      cmd_ok     <= cmd_ok_nxt;
      cmd_err    <= cmd_err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  // Frame sequencing, command execution and inter-byte timeout.
  always_comb begin
    state_nxt      = state;
    op_nxt         = op_q;
    argh_nxt       = argh_q;
    argl_nxt       = argl_q;
    sample_div_nxt = sample_div;
    trig_mask_nxt  = trig_mask;
    trig_val_nxt   = trig_val;
    trig_mode_nxt  = trig_mode;
    err_code_nxt   = err_code;
    arm_nxt        = 1'b0;
    abort_nxt      = 1'b0;
    cmd_ok_nxt     = 1'b0;
    cmd_err_nxt    = 1'b0;

    if (state == S_IDLE || rx_valid) cnt_nxt = '0;
    else                             cnt_nxt = cnt + CW'(1);

    case (state)
      S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_OP;
      S_OP: if (rx_valid) begin
        op_nxt    = rx_data;
        state_nxt = S_ARGH;
      end
      S_ARGH: if (rx_valid) begin
        argh_nxt  = rx_data;
        state_nxt = S_ARGL;
      end
      S_ARGL: if (rx_valid) begin
        argl_nxt  = rx_data;
        state_nxt = S_CHK;
      end
      S_CHK: if (rx_valid) begin
        state_nxt = S_IDLE;
        if (rx_data != (op_q ^ argh_q ^ argl_q)) begin
          cmd_err_nxt  = 1'b1;
          err_code_nxt = ERR_CHK;
        end else begin
          cmd_ok_nxt   = 1'b1;
          err_code_nxt = ERR_NONE;
          case (op_q)
            OP_SET_DIV:  sample_div_nxt = ({argh_q, argl_q} == 16'd0) ? 16'd1 : {argh_q, argl_q};
            OP_SET_MASK: trig_mask_nxt  = argl_q;
            OP_SET_VAL:  trig_val_nxt   = argl_q;
            OP_SET_MODE: trig_mode_nxt  = argl_q[1:0];
            OP_ARM:      arm_nxt        = 1'b1;
            OP_ABORT:    abort_nxt      = 1'b1;
            default: begin
              cmd_ok_nxt   = 1'b0;
              cmd_err_nxt  = 1'b1;
              err_code_nxt = ERR_OP;
            end
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    if (state != S_IDLE && !rx_valid && cnt == TMO_LAST) begin
      state_nxt    = S_IDLE;
      cnt_nxt      = '0;
      cmd_err_nxt  = 1'b1;
      err_code_nxt = ERR_TMO;
    end
  end

endmodule
